// File: rtl/wb_pkg.sv
// Shared constants, state encoding and bus field types for the Wishbone
// register slave.
package wb_pkg;

    localparam int ADDR_WIDTH     = 4;
    localparam int DATA_WIDTH     = 32;
    localparam int GRANULE        = 8;
    localparam int REGISTER_NUM   = 16;
    localparam int SEL_WIDTH      = DATA_WIDTH / GRANULE;
    localparam int WAIT_CNT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } wb_slv_state_t;

    typedef logic [ADDR_WIDTH-1:0] wb_addr_t;
    typedef logic [DATA_WIDTH-1:0] wb_data_t;
    typedef logic [SEL_WIDTH-1:0]  wb_sel_t;

endpackage

// File: rtl/wb_byte_reg_bank.sv
// Byte-lane writable register array with asynchronous active-low clear and
// one combinational read port. Writes to addresses at or above REGISTER_NUM
// are dropped; reads of such addresses return zero.
module wb_byte_reg_bank #(
    parameter int ADDR_WIDTH   = 4,
    parameter int DATA_WIDTH   = 32,
    parameter int GRANULE      = 8,
    parameter int REGISTER_NUM = 16,
    parameter int SEL_WIDTH    = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  wr_en_i,
    input  logic [ADDR_WIDTH-1:0] wr_adr_i,
    input  logic [DATA_WIDTH-1:0] wr_dat_i,
    input  logic [SEL_WIDTH-1:0]  wr_sel_i,
    input  logic [ADDR_WIDTH-1:0] rd_adr_i,
    output logic [DATA_WIDTH-1:0] rd_dat_o
);

    logic [DATA_WIDTH-1:0] mem_q [REGISTER_NUM];
    logic [DATA_WIDTH-1:0] mem_d [REGISTER_NUM];

    // Next array contents: only the enabled lanes of the addressed word change.
    always_comb begin
        mem_d = mem_q;
        for (int w = 0; w < REGISTER_NUM; w++) begin
            if (wr_en_i && (wr_adr_i == ADDR_WIDTH'(w))) begin
                for (int l = 0; l < SEL_WIDTH; l++) begin
                    if (wr_sel_i[l]) begin
                        mem_d[w][l*GRANULE +: GRANULE] = wr_dat_i[l*GRANULE +: GRANULE];
                    end
                end
            end
        end
    end

    // Read port decoded by compare so unimplemented addresses read as zero.
    always_comb begin
        rd_dat_o = '0;
        for (int w = 0; w < REGISTER_NUM; w++) begin
            if (rd_adr_i == ADDR_WIDTH'(w)) begin
                rd_dat_o = mem_q[w];
            end
        end
    end

    // Storage, cleared asynchronously.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int w = 0; w < REGISTER_NUM; w++) begin
                mem_q[w] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/wb_reg_slave.sv
// Wishbone B4 pipelined slave in front of a byte-addressable register bank.
//
// Handshake: a request is taken on a rising edge where cyc_i & stb_i & !stall_o;
// stall_o is high whenever the slave is not IDLE, so at most one request is in
// flight. The response (ack_o or err_o, never both) is a one-cycle pulse in the
// cycle WAIT_CYCLES+1 after acceptance, masked by cyc_i. Dropping cyc_i while
// waiting abandons the request without any side effect.
module wb_reg_slave
    import wb_pkg::wb_slv_state_t, wb_pkg::IDLE, wb_pkg::WAIT, wb_pkg::RESP;
#(
    parameter int ADDR_WIDTH   = wb_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH   = wb_pkg::DATA_WIDTH,
    parameter int GRANULE      = wb_pkg::GRANULE,
    parameter int REGISTER_NUM = wb_pkg::REGISTER_NUM,
    parameter int SEL_WIDTH    = DATA_WIDTH / GRANULE,
    parameter int WAIT_CYCLES  = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic [SEL_WIDTH-1:0]  sel_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  err_o,
    output logic                  stall_o,
    output wb_slv_state_t         dbg_state_o
);

    localparam int CNT_W = wb_pkg::WAIT_CNT_WIDTH;
    localparam logic [CNT_W-1:0] WAIT_LOAD =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    wb_slv_state_t         state_q, state_d;
    logic [CNT_W-1:0]      wait_cnt_q, wait_cnt_d;
    logic [ADDR_WIDTH-1:0] adr_q, adr_d;
    logic [DATA_WIDTH-1:0] wdat_q, wdat_d;
    logic [SEL_WIDTH-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
    logic                  ack_q, ack_d;
    logic                  err_q, err_d;

    logic                  accept;
    logic                  commit;
    logic                  adr_err;
    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_adr;
    logic [DATA_WIDTH-1:0] cur_dat;
    logic [SEL_WIDTH-1:0]  cur_sel;
    logic                  bank_we;
    logic [DATA_WIDTH-1:0] bank_rdat;

    // Command seen by the commit logic: with no wait states the commit edge is
    // the acceptance edge itself, so the live bus fields are used while IDLE.
    always_comb begin
        accept  = (state_q == IDLE) && cyc_i && stb_i;
        cur_we  = (state_q == IDLE) ? we_i  : we_q;
        cur_adr = (state_q == IDLE) ? adr_i : adr_q;
        cur_dat = (state_q == IDLE) ? dat_i : wdat_q;
        cur_sel = (state_q == IDLE) ? sel_i : sel_q;
        adr_err = (32'(cur_adr) >= 32'(REGISTER_NUM));
    end

    // FSM next state and wait counter.
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d    = WAIT;
                        wait_cnt_d = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                if (!cyc_i) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    wait_cnt_d = wait_cnt_q - 1'b1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Commit on the edge entering RESP: bank write, read data, response flags.
    always_comb begin
        commit  = (state_d == RESP);
        bank_we = commit && cur_we && !adr_err;
        ack_d   = commit && !adr_err;
        err_d   = commit && adr_err;
        rdat_d  = (commit && !cur_we && !adr_err) ? bank_rdat : rdat_q;
        adr_d   = accept ? adr_i : adr_q;
        wdat_d  = accept ? dat_i : wdat_q;
        sel_d   = accept ? sel_i : sel_q;
        we_d    = accept ? we_i  : we_q;
    end

    // State, counter, capture and output registers.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            adr_q      <= '0;
            wdat_q     <= '0;
            sel_q      <= '0;
            we_q       <= 1'b0;
            rdat_q     <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            adr_q      <= adr_d;
            wdat_q     <= wdat_d;
            sel_q      <= sel_d;
            we_q       <= we_d;
            rdat_q     <= rdat_d;
            ack_q      <= ack_d;
            err_q      <= err_d;
        end
    end

    // Bus outputs; a dropped cyc_i hides a response already committed.
    always_comb begin
        dat_o       = rdat_q;
        ack_o       = ack_q & cyc_i;
        err_o       = err_q & cyc_i;
        stall_o     = (state_q != IDLE);
        dbg_state_o = state_q;
    end

    wb_byte_reg_bank #(
        .ADDR_WIDTH   (ADDR_WIDTH),
        .DATA_WIDTH   (DATA_WIDTH),
        .GRANULE      (GRANULE),
        .REGISTER_NUM (REGISTER_NUM),
        .SEL_WIDTH    (SEL_WIDTH)
    ) u_bank (
        .clk_i    (clk_i),
        .rst_ni   (rst_i),
        .wr_en_i  (bank_we),
        .wr_adr_i (cur_adr),
        .wr_dat_i (cur_dat),
        .wr_sel_i (cur_sel),
        .rd_adr_i (cur_adr),
        .rd_dat_o (bank_rdat)
    );

endmodule

// File: doc/wb_reg_slave.md
Name: wb_reg_slave

Overview:
Wishbone B4 pipelined slave that answers the master on the existing `intf` bus with a byte-addressable register bank.
- Storage: REGISTER_NUM words of DATA_WIDTH bits, with byte-lane writes via sel_i.
- Latency: optional wait states; err_o on out-of-range addresses.
- Role: the memory target for the layered testbench and the RTL end of the bus.

Parameters:
ADDR_WIDTH, 4, word address width
DATA_WIDTH, 32, data bus width
GRANULE, 8, bits per select lane
REGISTER_NUM, 16, implemented words; legal addresses are 0..REGISTER_NUM-1 (REGISTER_NUM <= 2**ADDR_WIDTH)
SEL_WIDTH, DATA_WIDTH/GRANULE, select width (4)
WAIT_CYCLES, 0, extra cycles between acceptance and ack (0..15)

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  reset, asynchronous, active-low
cyc_i  in  1  bus cycle valid
stb_i  in  1  strobe, request valid
we_i  in  1  1=write, 0=read
adr_i  in  ADDR_WIDTH  word address
dat_i  in  DATA_WIDTH  write data from master
sel_i  in  SEL_WIDTH  byte-lane enables
dat_o  out  DATA_WIDTH  read data to master
ack_o  out  1  normal termination
err_o  out  1  error termination
stall_o  out  1  slave cannot accept a request

Behaviour:
- Reset (rst_i=0, asynchronous):
  - state=IDLE, wait_cnt=0, dat_o=0, ack_o=0, err_o=0, stall_o=0.
  - All registers cleared to 0.
- Acceptance: the request is accepted on a rising edge where cyc_i & stb_i & !stall_o. At that edge adr_i, dat_i, sel_i and we_i are captured.
- FSM states: IDLE, WAIT, RESP.
  - IDLE -> WAIT on acceptance when WAIT_CYCLES>0, loading wait_cnt=WAIT_CYCLES-1.
  - IDLE -> RESP on acceptance when WAIT_CYCLES=0.
  - WAIT: wait_cnt decrements each cycle; when wait_cnt==0 it goes to RESP.
  - RESP lasts exactly one cycle, then returns to IDLE.
- stall_o = (state != IDLE). There is no back-to-back acceptance, so peak throughput is one transfer per 2 cycles at WAIT_CYCLES=0.
- Latency: ack_o or err_o is high in the cycle WAIT_CYCLES+1 after the acceptance edge. The pulse is exactly one cycle. ack_o and err_o are never high together.
- Commit: all effects take place on the edge that enters RESP.
  - Legal write: for each lane i with sel_q[i]=1, reg[adr_q][i*GRANULE +: GRANULE] = dat_q lane i. Other lanes are unchanged.
  - Legal read: dat_o <= reg[adr_q].
  - dat_o holds its value at all other times, including after writes.
- sel=0: a legal write with sel_q=0 changes nothing but is still acked. A read ignores sel.
- Error: adr_q >= REGISTER_NUM gives err_o instead of ack_o, with no write and dat_o unchanged. It uses the same latency.
- Abort: cyc_i=0 in WAIT returns to IDLE on the next edge, with no commit and no ack/err. cyc_i=0 in RESP masks the outputs (ack_o = ack_q & cyc_i, same for err_o). The commit has already happened and the FSM returns to IDLE.
- Ignored inputs: stb_i without cyc_i is ignored. Inputs are not sampled while stall_o=1.
- Reset mid-transaction: the FSM goes to IDLE immediately and the outputs go to their reset values; there is no pending ack.

Decomposition:
- Package wb_pkg holds:
  - constants ADDR_WIDTH, DATA_WIDTH, GRANULE, REGISTER_NUM, SEL_WIDTH;
  - typedef enum logic [1:0] {IDLE, WAIT, RESP} wb_slv_state_t;
  - typedefs wb_addr_t, wb_data_t, wb_sel_t.
- These replace the current malformed `define macros in the interface.
- Sub-module wb_byte_reg_bank: synchronous byte-enabled register array with async active-low clear and one combinational read port. wb_reg_slave holds the FSM, wait counter, capture regs and error decode.

Test Plan:
- Reset, then write adr=3, dat=32'hDEADBEEF, sel=4'hF; read adr=3.
  - WAIT_CYCLES=0: ack_o one cycle after each acceptance, stall_o=1 during RESP.
  - Read returns dat_o=32'hDEADBEEF.
- Partial write: after the previous case, write adr=3, dat=32'h11223344, sel=4'b0101; read adr=3 -> 32'hDE22BE44. Then a write with sel=0 is acked and the value is unchanged.
- Errors with REGISTER_NUM=12:
  - Write adr=13 -> err_o=1 and ack_o=0 one cycle after acceptance.
  - Read adr=13 -> err_o, with dat_o still equal to the previous read value.
  - Read adr=11 -> ack_o with reg value 0.
- WAIT_CYCLES=3:
  - stb_i held high with stall_o honoured: ack_o appears 4 cycles after acceptance, and stall_o=1 for 4 cycles.
  - A second request is accepted in the cycle after ack_o.
- Abort: WAIT_CYCLES=3, write adr=5, dat=32'hA5A5A5A5, drop cyc_i 2 cycles after acceptance.
  - No ack/err; FSM back to IDLE.
  - A later read of adr=5 returns 0.
- Reset mid-wait: assert rst_i=0 asynchronously between edges during WAIT.
  - Outputs go to 0 immediately and registers read back as 0.
  - No ack after release.
